// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and the timing-region decode helper.
package vga_timing_pkg;

    localparam int H_ACTIVE_640 = 640;
    localparam int H_FP_640     = 16;
    localparam int H_SYNC_640   = 96;
    localparam int H_BP_640     = 48;
    localparam int V_ACTIVE_480 = 480;
    localparam int V_FP_480     = 10;
    localparam int V_SYNC_480   = 2;
    localparam int V_BP_480     = 33;
    localparam int CNT_W_DEF    = 10;

    typedef enum logic [1:0] {
        RGN_ACTIVE,
        RGN_FP,
        RGN_SYNC,
        RGN_BP
    } region_e;

    // Regions are laid out in order ACTIVE, FP, SYNC, BP from count 0.
    function automatic region_e region_of(input int cnt, input int act,
                                          input int fp, input int sync);
        if (cnt < act)                 return RGN_ACTIVE;
        else if (cnt < act + fp)       return RGN_FP;
        else if (cnt < act + fp + sync) return RGN_SYNC;
        else                           return RGN_BP;
    endfunction

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Modulo-(MAX_VAL+1) counter; wrap pulses on the enabled cycle it returns to 0.
module wrap_counter #(
    parameter int WIDTH   = 10,
    parameter int MAX_VAL = 799
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count;

    assign wrap  = en && (r_count == WIDTH'(MAX_VAL));
    assign count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (wrap)
            r_count <= '0;
        else if (en)
            r_count <= r_count + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/coordinate generator. Define VGA_TIMING_OUTREG_EN to register all
// outputs (one clk latency); otherwise outputs decode the counters directly.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_640,
    parameter int H_FP     = H_FP_640,
    parameter int H_SYNC   = H_SYNC_640,
    parameter int H_BP     = H_BP_640,
    parameter int V_ACTIVE = V_ACTIVE_480,
    parameter int V_FP     = V_FP_480,
    parameter int V_SYNC   = V_SYNC_480,
    parameter int V_BP     = V_BP_480,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be nonzero");
    end
    if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_bad_width
        $error("vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap_unused;

    wrap_counter #(.WIDTH(CNT_W), .MAX_VAL(H_TOTAL - 1)) u_h_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (w_h_cnt),
        .wrap  (w_h_wrap)
    );

    wrap_counter #(.WIDTH(CNT_W), .MAX_VAL(V_TOTAL - 1)) u_v_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_h_wrap),
        .count (w_v_cnt),
        .wrap  (w_v_wrap_unused)
    );

    region_e          w_h_rgn;
    region_e          w_v_rgn;
    logic             w_hs;
    logic             w_vs;
    logic             w_act;
    logic [CNT_W-1:0] w_x;
    logic [CNT_W-1:0] w_y;
    logic             w_ls;
    logic             w_fs;

    assign w_h_rgn = region_of(int'(w_h_cnt), H_ACTIVE, H_FP, H_SYNC);
    assign w_v_rgn = region_of(int'(w_v_cnt), V_ACTIVE, V_FP, V_SYNC);

    // rst gates the decode so the zeroed counters don't look like pixel (0,0)
    // while reset is held.
    assign w_act = rst && (w_h_rgn == RGN_ACTIVE) && (w_v_rgn == RGN_ACTIVE);
    assign w_hs  = (rst && (w_h_rgn == RGN_SYNC)) ? HS_POL : ~HS_POL;
    assign w_vs  = (rst && (w_v_rgn == RGN_SYNC)) ? VS_POL : ~VS_POL;
    assign w_x   = w_act ? w_h_cnt : '0;
    assign w_y   = w_act ? w_v_cnt : '0;
    assign w_ls  = rst && en && (w_h_cnt == '0);
    assign w_fs  = w_ls && (w_v_cnt == '0);

`ifdef VGA_TIMING_OUTREG_EN
    logic             r_hs;
    logic             r_vs;
    logic             r_act;
    logic [CNT_W-1:0] r_x;
    logic [CNT_W-1:0] r_y;
    logic             r_ls;
    logic             r_fs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs  <= ~HS_POL;
            r_vs  <= ~VS_POL;
            r_act <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_hs  <= w_hs;
            r_vs  <= w_vs;
            r_act <= w_act;
            r_x   <= w_x;
            r_y   <= w_y;
            r_ls  <= w_ls;
            r_fs  <= w_fs;
        end
    end

    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign active      = r_act;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
`else
    assign hsync       = w_hs;
    assign vsync       = w_vs;
    assign active      = w_act;
    assign x           = w_x;
    assign y           = w_y;
    assign line_start  = w_ls;
    assign frame_start = w_fs;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with a 14x7 reduced timing.
module tb_vga_timing_gen;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          hsync, vsync, active, line_start, frame_start;
    logic [CW-1:0] x, y;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .hsync       (hsync),
        .vsync       (vsync),
        .active      (active),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          act;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
    } obs_t;

    localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, act: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0};

    obs_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   phase = 0;
    int   mh = 0, mv = 0;
    logic cur_rst = 1'b0, cur_en = 1'b0;
    obs_t prev = RST_OBS;
    int   fs_t[$], fs_p[$], ls_t[$], ls_p[$];

    // Hand-derived decode for 8/2/2/2 x 4/1/1/1, active-low syncs.
    function automatic obs_t expect_of(input int h, input int v, input logic r, input logic e);
        obs_t o;
        o.act = r && (h < 8) && (v < 4);
        o.x   = o.act ? CW'(h) : '0;
        o.y   = o.act ? CW'(v) : '0;
        o.hs  = !(r && h >= 10 && h <= 11);
        o.vs  = !(r && v == 5);
        o.ls  = r && e && (h == 0);
        o.fs  = o.ls && (v == 0);
        return o;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e);
        obs_t cur;
        @(posedge clk);
        if (cur_rst && cur_en) begin
            if (mh == 13) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end
        #1;
        rst = r;
        en  = e;
        cur_rst = r;
        cur_en  = e;
        if (!r) begin
            mh = 0;
            mv = 0;
        end
        cyc++;
        cur = expect_of(mh, mv, r, e);
`ifdef VGA_TIMING_OUTREG_EN
        q.push_back(r ? prev : RST_OBS);
        prev = cur;
`else
        q.push_back(cur);
`endif
    endtask

    // Monitor: one observation per cycle, compared at the falling edge.
    initial begin
        obs_t got, exp;
        forever begin
            @(negedge clk);
            if (frame_start) begin fs_t.push_back(cyc); fs_p.push_back(phase); end
            if (line_start)  begin ls_t.push_back(cyc); ls_p.push_back(phase); end
            if (q.size() > 0) begin
                exp = q.pop_front();
                got = '{hs: hsync, vs: vsync, act: active, x: x, y: y, ls: line_start, fs: frame_start};
                n_cmp++;
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL obs cyc=%0d ph=%0d got hs%b vs%b act%b x%0d y%0d ls%b fs%b expected hs%b vs%b act%b x%0d y%0d ls%b fs%b",
                             cyc, phase, got.hs, got.vs, got.act, got.x, got.y, got.ls, got.fs,
                             exp.hs, exp.vs, exp.act, exp.x, exp.y, exp.ls, exp.fs);
                end
            end
        end
    end

    initial begin
        int n2, n3, k;
        rst = 1'b0;
        en  = 1'b1;

        phase = 1;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        phase = 2;
        for (int i = 0; i < 210; i++) step(1'b1, 1'b1);

        phase = 3;
        for (int i = 0; i < 400; i++) step(1'b1, (i % 2) == 0);

        phase = 4;
        k = 0;
        while (!(mh == 8 && mv == 5) && k < 200) begin
            step(1'b1, 1'b1);
            k++;
        end
        check("seek_h8_v5", (mh == 8 && mv == 5) ? 1 : 0, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 110; i++) step(1'b1, 1'b1);

        k = 0;
        while (q.size() > 0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        #1;
        check("queue_drained", q.size(), 0);

        n2 = 0;
        n3 = 0;
        for (int i = 1; i < fs_t.size(); i++) begin
            if (fs_p[i] == fs_p[i-1] && fs_p[i] == 2) begin
                check("fs_period_cont", fs_t[i] - fs_t[i-1], 98);
                n2++;
            end
            if (fs_p[i] == fs_p[i-1] && fs_p[i] == 3) begin
                check("fs_period_toggle", fs_t[i] - fs_t[i-1], 196);
                n3++;
            end
        end
        check("fs_pairs_cont", n2, 2);
        check("fs_pairs_toggle_seen", (n3 >= 1) ? 1 : 0, 1);
        for (int i = 1; i < ls_t.size(); i++) begin
            if (ls_p[i] == ls_p[i-1] && ls_p[i] == 2)
                check("ls_period_cont", ls_t[i] - ls_t[i-1], 14);
            if (ls_p[i] == ls_p[i-1] && ls_p[i] == 3)
                check("ls_period_toggle", ls_t[i] - ls_t[i-1], 28);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 2, 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL and VS_POL, default 0, asserted sync level; 0 means active-low.
REQ-006 SHALL have parameter CNT_W, default 10, width of counters and coordinates.
REQ-007 SHALL use one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  sole clock.
REQ-009 rst  input  1  asynchronous active-low reset.
REQ-010 en  input  1  pixel strobe; counters advance only when high.
REQ-011 hsync, vsync  output  1 each  sync pulses at HS_POL/VS_POL level.
REQ-012 active  output  1  high in visible region.
REQ-013 x, y  output  CNT_W each  pixel coordinates; 0 when active low.
REQ-014 line_start, frame_start  output  1 each  single-cycle pulses.

Function
REQ-015 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both derived at elaboration.
REQ-016 h_cnt SHALL increment on clk when en high; at H_TOTAL-1 it SHALL wrap to 0.
REQ-017 v_cnt SHALL increment only on the cycle h_cnt wraps; at V_TOTAL-1 it SHALL wrap to 0 on that same cycle.
REQ-018 en low SHALL hold both counters; pulse outputs SHALL be 0 that cycle; levels SHALL hold.
REQ-019 active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
REQ-020 hsync asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync same scheme in lines, independent of h_cnt.
REQ-021 line_start = en and h_cnt==0; frame_start = en and h_cnt==0 and v_cnt==0.
REQ-022 Outputs SHALL be combinational decode of counter registers: zero latency.
REQ-023 If CNT_W cannot represent H_TOTAL-1 or V_TOTAL-1, or any porch/sync parameter is 0, elaboration SHALL fail.

Reset
REQ-024 rst low SHALL clear h_cnt and v_cnt to 0 asynchronously, including mid-frame.
REQ-025 While rst low: active=0, x=y=0, pulses=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-026 First en cycle after rst release SHALL emit frame_start and line_start with active=1, x=y=0.

Configuration
REQ-027 Macro VGA_TIMING_OUTREG_EN defined: all outputs SHALL be registered, one clk latency versus counter state, reset values per REQ-025.
REQ-028 Macro undefined: outputs combinational per REQ-022; counter behaviour identical either way.

Structure
REQ-029 Package vga_timing_pkg SHALL hold 640x480@60 default constants and an H/V timing-region enum (ACTIVE, FP, SYNC, BP).
REQ-030 Sub-module wrap_counter (WIDTH, MAX_VAL; inputs clk, rst, en; outputs count, wrap) SHALL be instantiated twice, vertical en = horizontal wrap.

Verification (H 8/2/2/2 -> H_TOTAL 14; V 4/1/1/1 -> V_TOTAL 7; CNT_W 4; polarities 0)
REQ-031 rst low 3 cycles, en=1 -> hsync=vsync=1, active=0; first en cycle after release frame_start=1, x=y=0.
REQ-032 en=1 continuous -> hsync low exactly h_cnt 10..11; line_start every 14 cycles; frame_start every 98 cycles.
REQ-033 en toggled 1/0 -> counters advance every other cycle; no pulse on en-low cycles; period doubles to 196 cycles.
REQ-034 rst asserted at h_cnt=9, v_cnt=5 -> outputs go inactive immediately; restart at 0,0.
REQ-035 h_cnt=13, v_cnt=6, en=1 -> next cycle both 0, frame_start=1, vsync inactive.
REQ-036 VGA_TIMING_OUTREG_EN defined -> every output trails unregistered build by exactly one clk.
